lsu_stream_agu: RTL
===================

// Module: lsu_stream_agu
// PURPOSE
//  Parametrised load/store unit for one memory port of the PE array. A configurable strided
//  address generator (base/stride/count) replaces the free-running counter. A credit-limited
//  load queue absorbs variable read latency. Store data comes from a selected PE or from the
//  load-queue head. Sits between the PE array and the crossbar/bank arbiter.
// PARAMETERS
//  DW        32  data width of PE, load and store paths
//  AW        10  address width; address arithmetic wraps mod 2^AW
//  NUM_PE    4   number of PE data inputs (>=2)
//  PSEL_W    2   PE select width, = $clog2(NUM_PE)
//  LQ_DEPTH  4   load-queue entries (power of 2, >=2); also the outstanding-read credit limit
// PORTS
//  clk            in   1            clock
//  rst            in   1            synchronous active-high reset
//  cfg_we         in   1            load cfg_base/stride/count, start a stream
//  cfg_base       in   AW           first address
//  cfg_stride     in   AW           address increment per access (unsigned, wraps)
//  cfg_count      in   AW           number of accesses in stream
//  inst_ren       in   1            request a read this cycle
//  inst_wen       in   1            request a write this cycle
//  inst_w_sel     in   2            write bank/byte select, forwarded with write
//  inst_pe_sel    in   PSEL_W       PE source for store data
//  inst_store_sel in   1            1: store from load-queue head (pops it), 0: from PE
//  pe_data        in   NUM_PE*DW    PE outputs, PE i at [i*DW +: DW]
//  rd_valid       in   1            read data return strobe
//  rd_data        in   DW           read data
//  pe_pop         in   1            PE consumes load-queue head
//  lsu_to_pe      out  DW           load-queue head; all-ones when empty
//  lq_empty       out  1            load queue empty
//  r_req_valid    out  1            registered read request
//  r_req_addr     out  AW           read address
//  w_req_valid    out  1            registered write request
//  w_req_sel      out  2            registered inst_w_sel
//  w_req_addr     out  AW           write address
//  w_req_data     out  DW           write data
//  busy           out  1            stream in RUN
//  done           out  1            stream complete (level, until next cfg_we)
//  lq_overflow    out  1            sticky: rd_valid arrived with queue full (data dropped)
// BEHAVIOUR
//  Reset: FSM=IDLE; addr=0; remaining=0; credits=LQ_DEPTH; queue empty; r/w_req_valid=0;
//   r_req_addr=w_req_addr=0; w_req_sel=0; w_req_data=all-ones; busy=done=lq_overflow=0.
//  FSM IDLE->RUN on cfg_we (count!=0); IDLE->DONE on cfg_we with count==0.
//   RUN->DONE on the advance that takes remaining 1->0. DONE->RUN/DONE on cfg_we.
//   cfg_we has priority in every state: aborts the current stream and reloads addr/remaining.
//   In-flight reads still return and are queued. inst_* ignored in the cfg_we cycle.
//  Access op = inst_ren|inst_wen, valid only in RUN. Stall if:
//   (inst_ren && credits==0), or (inst_wen && inst_store_sel && lq_empty).
//  Non-stalled op, next edge: r_req_valid=inst_ren, w_req_valid=inst_wen, both addr=addr,
//   w_req_sel=inst_w_sel, w_req_data=store_sel ? lq head : PE[inst_pe_sel].
//   Then addr+=stride (mod 2^AW), remaining-=1. Read+write in one op share one address.
//   Stalled or no op: valids 0; addr/data regs hold.
//  Credits: -1 per issued read, +1 per pop (pe_pop or store-from-queue); both -> unchanged.
//   Credits never exceed LQ_DEPTH.
//  Load queue: FIFO, push on rd_valid, visible on lsu_to_pe the cycle after push.
//   Push+pop same cycle is legal at any occupancy (incl. full). pe_pop on empty ignored.
//   pe_pop and store-pop in the same cycle pop one entry.
//   Push when full without a pop: drop data, set lq_overflow (cleared only by rst).
//  busy = (state==RUN); done = (state==DONE); outputs are registered, no comb in->out path
//   except lsu_to_pe/lq_empty, which come from queue state.
// TESTING
//  base=0x010,stride=4,count=3, inst_ren every cycle, rd_valid 2 cycles later
//   -> r_req_addr 0x010,0x014,0x018; done after 3rd; lsu_to_pe pops in order.
//  base=0x3FC,stride=8,count=2, inst_wen, store_sel=0, pe_sel=2, PE2=0xA5A5A5A5
//   -> w_req_addr 0x3FC then 0x004 (wrap); w_req_data 0xA5A5A5A5.
//  LQ_DEPTH=4, 6 reads, no rd_valid
//   -> exactly 4 r_req_valid; stall holds addr; 5th issues the cycle after one rd_valid+pe_pop.
//  store_sel=1 with lq_empty -> no w_req_valid until rd_valid(0x12345678);
//   then write of 0x12345678 and queue pops.
//  cfg_we mid-stream (remaining=5) with 2 reads in flight
//   -> new base used next op; both old returns queued; no overflow.
//  Force rd_valid with queue full and no pop
//   -> lq_overflow=1, head unchanged; rst clears all to reset values.

Source files
------------

// File: rtl/lsu_stream_agu_if.sv
// rtl/lsu_stream_agu_if.sv - memory-side request/return bundle between LSU and bank arbiter
interface lsu_stream_agu_if #(
    parameter int DW = 32,
    parameter int AW = 10
);
    logic          r_req_valid;
    logic [AW-1:0] r_req_addr;
    logic          w_req_valid;
    logic [1:0]    w_req_sel;
    logic [AW-1:0] w_req_addr;
    logic [DW-1:0] w_req_data;
    logic          rd_valid;
    logic [DW-1:0] rd_data;

    modport master (
        output r_req_valid, r_req_addr,
        output w_req_valid, w_req_sel, w_req_addr, w_req_data,
        input  rd_valid, rd_data
    );

    modport slave (
        input  r_req_valid, r_req_addr,
        input  w_req_valid, w_req_sel, w_req_addr, w_req_data,
        output rd_valid, rd_data
    );
endinterface

// File: rtl/lsu_stream_agu.sv
// rtl/lsu_stream_agu.sv - strided load/store address generator with credit-limited load queue
module lsu_stream_agu #(
    parameter int DW       = 32,
    parameter int AW       = 10,
    parameter int NUM_PE   = 4,
    parameter int PSEL_W   = 2,
    parameter int LQ_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_we,
    input  logic [AW-1:0]        cfg_base,
    input  logic [AW-1:0]        cfg_stride,
    input  logic [AW-1:0]        cfg_count,
    input  logic                 inst_ren,
    input  logic                 inst_wen,
    input  logic [1:0]           inst_w_sel,
    input  logic [PSEL_W-1:0]    inst_pe_sel,
    input  logic                 inst_store_sel,
    input  logic [NUM_PE*DW-1:0] pe_data,
    input  logic                 pe_pop,
    output logic [DW-1:0]        lsu_to_pe,
    output logic                 lq_empty,
    output logic                 busy,
    output logic                 done,
    output logic                 lq_overflow,
    lsu_stream_agu_if.master     mem
);
    localparam int PTR_W = $clog2(LQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] LQ_FULL_CNT = CNT_W'(LQ_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     addr_q, stride_q, remaining_q;
    logic [CNT_W-1:0]  credits_q, lq_count_q;
    logic [PTR_W-1:0]  lq_rptr_q, lq_wptr_q;
    logic [DW-1:0]     lq_mem [LQ_DEPTH];
    logic              overflow_q;

    logic [DW-1:0]     pe_word [NUM_PE];
    logic              lq_full, op_valid, stall, issue, issue_rd;
    logic              store_pop, lq_pop, lq_push;
    logic [DW-1:0]     store_data;

    for (genvar i = 0; i < NUM_PE; i++) begin : g_pe_word
        assign pe_word[i] = pe_data[i*DW +: DW];
    end

    assign lq_full   = (lq_count_q == LQ_FULL_CNT);
    assign lq_empty  = (lq_count_q == '0);
    assign lsu_to_pe = lq_empty ? '1 : lq_mem[lq_rptr_q];

    // A reconfiguration cycle swallows any instruction presented alongside it.
    assign op_valid  = (state_q == S_RUN) && !cfg_we && (inst_ren || inst_wen);
    assign stall     = (inst_ren && (credits_q == '0)) ||
                       (inst_wen && inst_store_sel && lq_empty);
    assign issue     = op_valid && !stall;
    assign issue_rd  = issue && inst_ren;
    assign store_pop = issue && inst_wen && inst_store_sel;
    assign lq_pop    = store_pop || (pe_pop && !lq_empty);
    assign lq_push   = mem.rd_valid && (!lq_full || lq_pop);
    assign store_data = inst_store_sel ? lsu_to_pe : pe_word[inst_pe_sel];

    assign busy        = (state_q == S_RUN);
    assign done        = (state_q == S_DONE);
    assign lq_overflow = overflow_q;

    always_comb begin
        state_d = state_q;
        if (cfg_we) begin
            state_d = (cfg_count == '0) ? S_DONE : S_RUN;
        end else if (issue && (remaining_q == AW'(1))) begin
            state_d = S_DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            addr_q          <= '0;
            stride_q        <= '0;
            remaining_q     <= '0;
            credits_q       <= LQ_FULL_CNT;
            lq_count_q      <= '0;
            lq_rptr_q       <= '0;
            lq_wptr_q       <= '0;
            overflow_q      <= 1'b0;
            mem.r_req_valid <= 1'b0;
            mem.r_req_addr  <= '0;
            mem.w_req_valid <= 1'b0;
            mem.w_req_sel   <= '0;
            mem.w_req_addr  <= '0;
            mem.w_req_data  <= '1;
        end else begin
            state_q <= state_d;

            if (cfg_we) begin
                addr_q      <= cfg_base;
                stride_q    <= cfg_stride;
                remaining_q <= cfg_count;
            end else if (issue) begin
                addr_q      <= addr_q + stride_q;
                remaining_q <= remaining_q - AW'(1);
            end

            mem.r_req_valid <= issue_rd;
            mem.w_req_valid <= issue && inst_wen;
            if (issue) begin
                mem.r_req_addr <= addr_q;
                mem.w_req_addr <= addr_q;
                mem.w_req_sel  <= inst_w_sel;
                mem.w_req_data <= store_data;
            end

            // Credits track free queue slots; a pop returning a slot cancels an issuing read.
            case ({issue_rd, lq_pop})
                2'b10:   credits_q <= credits_q - CNT_W'(1);
                2'b01:   if (credits_q != LQ_FULL_CNT) credits_q <= credits_q + CNT_W'(1);
                default: credits_q <= credits_q;
            endcase

            if (lq_push) lq_wptr_q <= lq_wptr_q + PTR_W'(1);
            if (lq_pop)  lq_rptr_q <= lq_rptr_q + PTR_W'(1);
            case ({lq_push, lq_pop})
                2'b10:   lq_count_q <= lq_count_q + CNT_W'(1);
                2'b01:   lq_count_q <= lq_count_q - CNT_W'(1);
                default: lq_count_q <= lq_count_q;
            endcase

            if (mem.rd_valid && lq_full && !lq_pop) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (lq_push) lq_mem[lq_wptr_q] <= mem.rd_data;
    end
endmodule
